// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions: response codes used by the interconnect and its
// slaves, and the state encoding of the SRAM slave controller.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WRESP
    } state_t;

endpackage

// File: rtl/axi_sram_mem.sv
// ---------------------------------------------------------------------------
// axi_sram_mem
// Behavioural DEPTH x 32 word memory: one write port and one read port with
// a registered output. The read register only loads when re is high, so the
// output holds the last word read while the reader is stalled.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr       read enable / read word index
//   rdata          registered read data
// ---------------------------------------------------------------------------
module axi_sram_mem
    import axi_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI slave endpoint backed by an on-chip DEPTH x 32 memory. Serves one
// transaction at a time: fixed-length incrementing read bursts (BURST_LEN
// beats) and write bursts terminated by wlast. Word index = addr[ADDR_W+1:2],
// bursts wrap modulo DEPTH. Reads and writes alternate priority when both
// address channels are valid in the same idle cycle.
//
// Optional build macro AXI_SRAM_ADDR_CHECK_EN: beats whose full running
// address falls outside the BASE_ADDR region answer SLVERR (read data 0,
// writes suppressed with a sticky error reported on B).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   s_ar*  (valid/ready/addr)    read address channel
//   s_r*   (valid/ready/last/data/resp) read data channel
//   s_aw*  (valid/ready/addr)    write address channel
//   s_w*   (valid/ready/last/data) write data channel
//   s_b*   (valid/ready/resp)    write response channel
// ---------------------------------------------------------------------------
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          BURST_LEN = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_arvalid_i,
    output logic        s_arready_o,
    input  logic [31:0] s_araddr_i,
    output logic        s_rvalid_o,
    input  logic        s_rready_i,
    output logic        s_rlast_o,
    output logic [31:0] s_rdata_o,
    output logic [1:0]  s_rresp_o,
    input  logic        s_awvalid_i,
    output logic        s_awready_o,
    input  logic [31:0] s_awaddr_i,
    input  logic        s_wvalid_i,
    output logic        s_wready_o,
    input  logic        s_wlast_i,
    input  logic [31:0] s_wdata_i,
    output logic        s_bvalid_o,
    input  logic        s_bready_i,
    output logic [1:0]  s_bresp_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

`ifdef AXI_SRAM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Running addresses are full 30-bit word addresses so the range check
    // sees a burst walking off the end of the region instead of wrapping.
    function automatic logic out_of_range(input logic [29:0] word_addr);
        return CHECK_EN && (word_addr[29:ADDR_W] != BASE_ADDR[31:ADDR_W+2]);
    endfunction

    state_t            state;
    logic              prio_rd;
    logic              rvalid;
    logic [CNT_W-1:0]  beat_cnt;
    logic              rd_err;
    logic              wr_err;
    logic [29:0]       rd_waddr;
    logic [29:0]       wr_waddr;
    logic [29:0]       rd_next;
    logic              ar_hs;
    logic              aw_hs;
    logic              r_hs;
    logic              w_hs;
    logic              rlast;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_rdata;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_araddr_i[1:0], s_awaddr_i[1:0]};

    assign s_arready_o = (state == ST_IDLE) && (!s_awvalid_i || prio_rd);
    assign s_awready_o = (state == ST_IDLE) && (!s_arvalid_i || !prio_rd);

    assign ar_hs = s_arvalid_i && s_arready_o;
    assign aw_hs = s_awvalid_i && s_awready_o;
    assign r_hs  = rvalid && s_rready_i;
    assign w_hs  = (state == ST_WR) && s_wvalid_i;
    assign rlast = rvalid && (beat_cnt == LAST_BEAT);

    // Address of the beat being fetched this cycle: the AR address when a
    // burst starts, otherwise the beat after the one currently presented.
    assign rd_next = (state == ST_IDLE) ? s_araddr_i[31:2] : rd_waddr + 30'd1;

    // A fetch on every non-last handshake keeps one beat per cycle flowing;
    // with no fetch the memory output register holds the presented beat.
    assign mem_re = ar_hs || (r_hs && !rlast);
    assign mem_we = w_hs && !out_of_range(wr_waddr);

    axi_sram_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk_i),
        .we    (mem_we),
        .waddr (wr_waddr[ADDR_W-1:0]),
        .wdata (s_wdata_i),
        .re    (mem_re),
        .raddr (rd_next[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_RST;
            prio_rd  <= 1'b1;
            rvalid   <= 1'b0;
            beat_cnt <= '0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    wr_err <= 1'b0;
                    if (ar_hs) begin
                        state    <= ST_RD;
                        prio_rd  <= 1'b0;
                        rvalid   <= 1'b1;
                        beat_cnt <= '0;
                        rd_err   <= out_of_range(rd_next);
                    end else if (aw_hs) begin
                        state   <= ST_WR;
                        prio_rd <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            rd_err   <= out_of_range(rd_next);
                        end
                    end
                end
                ST_WR: begin
                    if (w_hs) begin
                        if (out_of_range(wr_waddr)) begin
                            wr_err <= 1'b1;
                        end
                        if (s_wlast_i) begin
                            state <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_bready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_re) begin
            rd_waddr <= rd_next;
        end
        if (aw_hs) begin
            wr_waddr <= s_awaddr_i[31:2];
        end else if (w_hs) begin
            wr_waddr <= wr_waddr + 30'd1;
        end
    end

    // Data and response are gated by the valid flags so every output is
    // zero while in reset, independent of the unreset memory register.
    assign s_rvalid_o = rvalid;
    assign s_rlast_o  = rlast;
    assign s_rdata_o  = (rvalid && !rd_err) ? mem_rdata : 32'h0;
    assign s_rresp_o  = (rvalid && rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_wready_o = (state == ST_WR);
    assign s_bvalid_o = (state == ST_WRESP);
    assign s_bresp_o  = ((state == ST_WRESP) && wr_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Bench for axi_sram_slave with two instances (DEPTH 16): index 0 has
// BURST_LEN 1, index 1 has BURST_LEN 4. Expected values depend on whether
// AXI_SRAM_ADDR_CHECK_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

`ifdef AXI_SRAM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  arvalid, arready, rvalid, rready, rlast;
    logic [1:0]  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] araddr [2];
    logic [31:0] rdata  [2];
    logic [31:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [1:0]  rresp  [2];
    logic [1:0]  bresp  [2];

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave #(.DEPTH(16), .BURST_LEN(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .s_arvalid_i(arvalid[0]), .s_arready_o(arready[0]), .s_araddr_i(araddr[0]),
        .s_rvalid_o(rvalid[0]), .s_rready_i(rready[0]), .s_rlast_o(rlast[0]),
        .s_rdata_o(rdata[0]), .s_rresp_o(rresp[0]),
        .s_awvalid_i(awvalid[0]), .s_awready_o(awready[0]), .s_awaddr_i(awaddr[0]),
        .s_wvalid_i(wvalid[0]), .s_wready_o(wready[0]), .s_wlast_i(wlast[0]),
        .s_wdata_i(wdata[0]), .s_bvalid_o(bvalid[0]), .s_bready_i(bready[0]),
        .s_bresp_o(bresp[0])
    );

    axi_sram_slave #(.DEPTH(16), .BURST_LEN(4), .BASE_ADDR(32'h0)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .s_arvalid_i(arvalid[1]), .s_arready_o(arready[1]), .s_araddr_i(araddr[1]),
        .s_rvalid_o(rvalid[1]), .s_rready_i(rready[1]), .s_rlast_o(rlast[1]),
        .s_rdata_o(rdata[1]), .s_rresp_o(rresp[1]),
        .s_awvalid_i(awvalid[1]), .s_awready_o(awready[1]), .s_awaddr_i(awaddr[1]),
        .s_wvalid_i(wvalid[1]), .s_wready_o(wready[1]), .s_wlast_i(wlast[1]),
        .s_wdata_i(wdata[1]), .s_bvalid_o(bvalid[1]), .s_bready_i(bready[1]),
        .s_bresp_o(bresp[1])
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %b expected %b", name, sel, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %b expected %b", name, sel, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, sel, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_arready"}, arready[sel], 1'b0);
        chk1({tag, "_awready"}, awready[sel], 1'b0);
        chk1({tag, "_rvalid"},  rvalid[sel],  1'b0);
        chk1({tag, "_rlast"},   rlast[sel],   1'b0);
        chk32({tag, "_rdata"},  rdata[sel],   32'h0);
        chk2({tag, "_rresp"},   rresp[sel],   2'b00);
        chk1({tag, "_wready"},  wready[sel],  1'b0);
        chk1({tag, "_bvalid"},  bvalid[sel],  1'b0);
        chk2({tag, "_bresp"},   bresp[sel],   2'b00);
    endtask

    task automatic do_ar(input logic [31:0] a);
        int n = 0;
        arvalid[sel] = 1'b1;
        araddr[sel]  = a;
        #1;
        while (!arready[sel] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk1("ar_grant", arready[sel], 1'b1);
        step();
        arvalid[sel] = 1'b0;
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        awvalid[sel] = 1'b1;
        awaddr[sel]  = a;
        #1;
        while (!awready[sel] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk1("aw_grant", awready[sel], 1'b1);
        step();
        awvalid[sel] = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic last);
        int n = 0;
        wvalid[sel] = 1'b1;
        wdata[sel]  = d;
        wlast[sel]  = last;
        #1;
        while (!wready[sel] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk1("wready", wready[sel], 1'b1);
        step();
        wvalid[sel] = 1'b0;
        wlast[sel]  = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] a, input int n, input logic [31:0] d [4],
                               input logic [1:0] eb);
        do_aw(a);
        for (int i = 0; i < n; i++) begin
            do_w(d[i], i == n - 1);
        end
        chk1("bvalid", bvalid[sel], 1'b1);
        chk2("bresp", bresp[sel], eb);
        bready[sel] = 1'b1;
        step();
        bready[sel] = 1'b0;
        chk1("bvalid_clr", bvalid[sel], 1'b0);
    endtask

    task automatic read_burst(input logic [31:0] a, input int n, input logic [31:0] d [4],
                              input logic [1:0] rs [4]);
        do_ar(a);
        chk1("rvalid_rise", rvalid[sel], 1'b1);
        rready[sel] = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk1("rvalid", rvalid[sel], 1'b1);
            chk1("rlast", rlast[sel], i == n - 1);
            chk2("rresp", rresp[sel], rs[i]);
            chk32("rdata", rdata[sel], d[i]);
            step();
        end
        rready[sel] = 1'b0;
        chk1("rvalid_done", rvalid[sel], 1'b0);
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [31:0] d4   [4];
        logic [1:0]  ok4  [4];
        logic [1:0]  rs4  [4];

        // single-beat write then read on the BURST_LEN 1 instance
        vecs[0] = '{32'h10, 32'hDEADBEEF, 2'b00, 32'h10, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h24, 32'h12345678, 2'b00, 32'h27, 32'h12345678, 2'b00};
        vecs[2] = '{32'h00, 32'h00000F0F, 2'b00, 32'h00, 32'h00000F0F, 2'b00};
        vecs[3] = '{32'h3C, 32'hA5A5A5A5, 2'b00, 32'h3C, 32'hA5A5A5A5, 2'b00};
        vecs[4] = '{32'h40, 32'hCAFEF00D, CHK ? 2'b10 : 2'b00,
                    32'h00, CHK ? 32'h00000F0F : 32'hCAFEF00D, 2'b00};
        vecs[5] = '{32'h10, 32'h00000001, 2'b00,
                    32'h50, CHK ? 32'h0 : 32'h00000001, CHK ? 2'b10 : 2'b00};
        ok4 = '{2'b00, 2'b00, 2'b00, 2'b00};

        rst = 1'b1;
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
        for (int s = 0; s < 2; s++) begin
            araddr[s] = '0; awaddr[s] = '0; wdata[s] = '0;
        end
        // both address channels valid on the BURST_LEN 4 instance from reset
        arvalid[1] = 1'b1; araddr[1] = 32'h20;
        awvalid[1] = 1'b1; awaddr[1] = 32'h20;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk_all_zero("reset");
        end

        // ---- contention: read first, then write, then read again
        sel = 1;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk1("prio_arready", arready[1], 1'b1);
        chk1("prio_awready", awready[1], 1'b0);
        step();
        chk1("prio_rd_rvalid", rvalid[1], 1'b1);
        rready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("prio_rd_rlast", rlast[1], i == 3);
            step();
        end
        rready[1] = 1'b0;
        chk1("prio2_awready", awready[1], 1'b1);
        chk1("prio2_arready", arready[1], 1'b0);
        step();
        awvalid[1] = 1'b0;
        do_w(32'h55, 1'b1);
        chk1("prio_bvalid", bvalid[1], 1'b1);
        bready[1] = 1'b1;
        step();
        bready[1] = 1'b0;
        chk1("prio3_arready", arready[1], 1'b1);
        step();
        arvalid[1] = 1'b0;
        chk1("prio3_rvalid", rvalid[1], 1'b1);
        chk32("prio3_rdata", rdata[1], 32'h55);
        rready[1] = 1'b1;
        repeat (4) step();
        rready[1] = 1'b0;
        chk1("prio3_done", rvalid[1], 1'b0);

        // ---- table-driven single-beat vectors
        sel = 0;
        for (int v = 0; v < 6; v++) begin
            d4  = '{vecs[v].wdata, 32'h0, 32'h0, 32'h0};
            write_burst(vecs[v].waddr, 1, d4, vecs[v].bresp);
            d4  = '{vecs[v].rdata, 32'h0, 32'h0, 32'h0};
            rs4 = '{vecs[v].rresp, 2'b00, 2'b00, 2'b00};
            read_burst(vecs[v].raddr, 1, d4, rs4);
        end

        // ---- 4-beat write then 4-beat read
        sel = 1;
        d4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_burst(32'h0, 4, d4, 2'b00);
        read_burst(32'h0, 4, d4, ok4);

        // ---- read backpressure: stall 3 cycles on beat 1
        do_ar(32'h0);
        rready[1] = 1'b1;
        chk32("bp_b0", rdata[1], 32'h11);
        step();
        rready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("bp_rvalid", rvalid[1], 1'b1);
            chk32("bp_hold", rdata[1], 32'h22);
            chk1("bp_rlast", rlast[1], 1'b0);
            step();
        end
        rready[1] = 1'b1;
        chk32("bp_b1", rdata[1], 32'h22);
        step();
        chk32("bp_b2", rdata[1], 32'h33);
        chk1("bp_b2_last", rlast[1], 1'b0);
        step();
        chk32("bp_b3", rdata[1], 32'h44);
        chk1("bp_b3_last", rlast[1], 1'b1);
        step();
        rready[1] = 1'b0;
        chk1("bp_done", rvalid[1], 1'b0);

        // ---- write crossing the top word
        d4 = '{32'hAAAA0001, 32'hAAAA0002, 32'h0, 32'h0};
        write_burst(32'h3C, 2, d4, CHK ? 2'b10 : 2'b00);
        d4  = CHK ? '{32'hAAAA0001, 32'h0, 32'h0, 32'h0}
                  : '{32'hAAAA0001, 32'hAAAA0002, 32'h22, 32'h33};
        rs4 = CHK ? '{2'b00, 2'b10, 2'b10, 2'b10} : ok4;
        read_burst(32'h3C, 4, d4, rs4);
        d4 = '{CHK ? 32'h11 : 32'hAAAA0002, 32'h22, 32'h33, 32'h44};
        read_burst(32'h0, 4, d4, ok4);

        // ---- reset in the middle of a read burst
        do_ar(32'h0);
        chk1("mid_rvalid", rvalid[1], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        step();
        read_burst(32'h0, 4, d4, ok4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
